// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared FSM state encoding for the APB round-robin arbiter
package apb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

endpackage

// File: rtl/rr_prio_sel.sv
// rtl/rr_prio_sel.sv - combinational round-robin first-one finder starting at rr_ptr
module rr_prio_sel #(
    parameter int NB_REQ = 3,
    parameter int IDX_W  = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
    input  logic [NB_REQ-1:0] req,
    input  logic [IDX_W-1:0]  rr_ptr,
    output logic              valid,
    output logic [IDX_W-1:0]  idx
);

    // Offsets are walked from farthest to nearest so the nearest set bit
    // (lowest offset from rr_ptr) is the last assignment and wins.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = NB_REQ - 1; i >= 0; i--) begin
            for (int j = 0; j < NB_REQ; j++) begin
                if (rr_ptr == IDX_W'(j) && req[(j + i) % NB_REQ]) begin
                    idx = IDX_W'((j + i) % NB_REQ);
                end
            end
        end
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - round-robin sharing of one downstream APB port among NB_REQ requesters
module apb_rr_arbiter
    import apb_pkg::*;
#(
    parameter int  NB_REQ         = 3,
    parameter int  APB_ADDR_WIDTH = 32,
    parameter int  APB_DATA_WIDTH = 32,
    localparam int IDX_W          = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NB_REQ*APB_ADDR_WIDTH-1:0]   apb_req_paddr,
    input  logic [NB_REQ*APB_DATA_WIDTH-1:0]   apb_req_pwdata,
    input  logic [NB_REQ-1:0]                  apb_req_pwrite,
    input  logic [NB_REQ-1:0]                  apb_req_psel,
    input  logic [NB_REQ-1:0]                  apb_req_penable,
    output logic [NB_REQ*APB_DATA_WIDTH-1:0]   apb_req_prdata,
    output logic [NB_REQ-1:0]                  apb_req_pready,
    output logic [NB_REQ-1:0]                  apb_req_pslverr,
    output logic [APB_ADDR_WIDTH-1:0]          apb_master_paddr,
    output logic [APB_DATA_WIDTH-1:0]          apb_master_pwdata,
    output logic                               apb_master_pwrite,
    output logic                               apb_master_psel,
    output logic                               apb_master_penable,
    input  logic [APB_DATA_WIDTH-1:0]          apb_master_prdata,
    input  logic                               apb_master_pready,
    input  logic                               apb_master_pslverr
);

    logic [1:0]       state;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] next_ptr;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_valid;
    logic             busy;
    logic             done;

    // Requests are qualified by psel alone; penable is intentionally ignored.
    logic unused_penable;
    assign unused_penable = ^apb_req_penable;

    rr_prio_sel #(
        .NB_REQ (NB_REQ),
        .IDX_W  (IDX_W)
    ) u_rr_prio_sel (
        .req    (apb_req_psel),
        .rr_ptr (rr_ptr),
        .valid  (sel_valid),
        .idx    (sel_idx)
    );

    assign busy     = (state == ST_SETUP) || (state == ST_ACCESS);
    assign done     = (state == ST_ACCESS) && apb_master_pready;
    assign next_ptr = (grant_idx == IDX_W'(NB_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            grant_idx <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        grant_idx <= sel_idx;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: state <= ST_ACCESS;
                ST_ACCESS: begin
                    // The just-served requester drops to lowest priority.
                    if (apb_master_pready) begin
                        rr_ptr <= next_ptr;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign apb_master_psel    = busy;
    assign apb_master_penable = (state == ST_ACCESS);
    assign apb_master_paddr   = busy ? apb_req_paddr[int'(grant_idx)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH] : '0;
    assign apb_master_pwdata  = busy ? apb_req_pwdata[int'(grant_idx)*APB_DATA_WIDTH +: APB_DATA_WIDTH] : '0;
    assign apb_master_pwrite  = busy ? apb_req_pwrite[grant_idx] : 1'b0;

    // Only the owner sees the completion; everyone else stays in wait states.
    always_comb begin
        apb_req_pready  = '0;
        apb_req_pslverr = '0;
        apb_req_prdata  = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            if (done && grant_idx == IDX_W'(k)) begin
                apb_req_pready[k]                                   = 1'b1;
                apb_req_pslverr[k]                                  = apb_master_pslverr;
                apb_req_prdata[k*APB_DATA_WIDTH +: APB_DATA_WIDTH]  = apb_master_prdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// tb/tb_apb_rr_arbiter.sv - directed self-checking bench for apb_rr_arbiter
module tb_apb_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] req_paddr;
    logic [95:0] req_pwdata;
    logic [2:0]  req_pwrite;
    logic [2:0]  req_psel;
    logic [2:0]  req_penable;
    logic [95:0] req_prdata;
    logic [2:0]  req_pready;
    logic [2:0]  req_pslverr;
    logic [31:0] m_paddr;
    logic [31:0] m_pwdata;
    logic        m_pwrite;
    logic        m_psel;
    logic        m_penable;
    logic [31:0] m_prdata;
    logic        m_pready;
    logic        m_pslverr;

    int vectors    = 0;
    int miscompares = 0;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];

    apb_rr_arbiter dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .apb_req_paddr      (req_paddr),
        .apb_req_pwdata     (req_pwdata),
        .apb_req_pwrite     (req_pwrite),
        .apb_req_psel       (req_psel),
        .apb_req_penable    (req_penable),
        .apb_req_prdata     (req_prdata),
        .apb_req_pready     (req_pready),
        .apb_req_pslverr    (req_pslverr),
        .apb_master_paddr   (m_paddr),
        .apb_master_pwdata  (m_pwdata),
        .apb_master_pwrite  (m_pwrite),
        .apb_master_psel    (m_psel),
        .apb_master_penable (m_penable),
        .apb_master_prdata  (m_prdata),
        .apb_master_pready  (m_pready),
        .apb_master_pslverr (m_pslverr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load_req();
        for (int k = 0; k < 3; k++) begin
            req_paddr[k*32 +: 32]  = addr[k];
            req_pwdata[k*32 +: 32] = wdata[k];
        end
    endtask

    initial begin
        rst = 1'b1;
        req_psel = '0; req_penable = '0; req_pwrite = '0;
        for (int k = 0; k < 3; k++) begin
            addr[k]  = 32'h1000_0000 + 32'(k) * 32'h100;
            wdata[k] = 32'hA0A0_0000 + 32'(k);
        end
        load_req();
        m_prdata = '0; m_pready = 1'b1; m_pslverr = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("reset_psel", m_psel, 0);
        chk("reset_penable", m_penable, 0);
        chk("reset_paddr", m_paddr, 0);
        chk("reset_pready", req_pready, 0);
        chk("reset_rr_ptr", dut.rr_ptr, 0);

        // Contention: all three together from rr_ptr=0 -> owners 0,1,2, 3 cycles each
        req_psel = 3'b111; req_pwrite = 3'b111;
        m_prdata = 32'h0000_5555;
        #1;
        chk("cont_no_comb_psel", m_psel, 0);
        for (int o = 0; o < 3; o++) begin
            step(); #1;
            chk($sformatf("cont%0d_setup_psel", o), {m_psel, m_penable}, 2'b10);
            chk($sformatf("cont%0d_paddr", o), m_paddr, addr[o]);
            chk($sformatf("cont%0d_pwdata", o), m_pwdata, wdata[o]);
            chk($sformatf("cont%0d_pwrite", o), m_pwrite, 1);
            step(); #1;
            chk($sformatf("cont%0d_access", o), {m_psel, m_penable}, 2'b11);
            chk($sformatf("cont%0d_pready", o), req_pready, 3'b001 << o);
            step();
            req_psel[o] = 1'b0;
            #1;
            chk($sformatf("cont%0d_idle", o), m_psel, 0);
        end

        // Single read from requester 1
        addr[1] = 32'h1A10_2000; load_req();
        req_psel = 3'b010; req_pwrite = 3'b000;
        m_prdata = 32'hDEAD_BEEF;
        #1;
        chk("rd_c0_psel", m_psel, 0);
        step(); #1;
        chk("rd_c1_sel_en", {m_psel, m_penable}, 2'b10);
        chk("rd_c1_paddr", m_paddr, 32'h1A10_2000);
        chk("rd_c1_pwrite", m_pwrite, 0);
        chk("rd_c1_pready", req_pready, 0);
        step(); #1;
        chk("rd_c2_sel_en", {m_psel, m_penable}, 2'b11);
        chk("rd_c2_pready", req_pready, 3'b010);
        chk("rd_c2_prdata", req_prdata, {32'h0, 32'hDEAD_BEEF, 32'h0});
        step();
        req_psel = 3'b000;
        #1;
        chk("rd_c3_idle", m_psel, 0);

        // Fairness: rr_ptr=2, req0 alone, req2 joins, req0 re-requests at once
        req_psel = 3'b001;
        step();
        req_psel = 3'b101;
        #1;
        chk("fair_first_owner0", m_paddr, addr[0]);
        step(); #1;
        chk("fair_pready0", req_pready, 3'b001);
        step(); step(); #1;
        chk("fair_second_owner2", m_paddr, addr[2]);
        step(); #1;
        chk("fair_pready2", req_pready, 3'b100);
        step();
        req_psel = 3'b001;
        step(); #1;
        chk("fair_third_owner0", m_paddr, addr[0]);
        step(); #1;
        chk("fair_pready0b", req_pready, 3'b001);
        step();
        req_psel = 3'b000;

        // Wait states + slave error, requester 1 (rr_ptr=1)
        req_psel = 3'b010; m_pready = 1'b0; m_prdata = 32'h1234_5678;
        step(); step();
        for (int w = 0; w < 4; w++) begin
            #1;
            chk($sformatf("ws%0d_pready", w), req_pready, 0);
            chk($sformatf("ws%0d_master", w), {m_psel, m_penable, m_pwrite, m_paddr}, {3'b110, addr[1]});
            step();
        end
        m_pready = 1'b1; m_pslverr = 1'b1;
        #1;
        chk("ws_done_pready", req_pready, 3'b010);
        chk("ws_done_pslverr", req_pslverr, 3'b010);
        chk("ws_done_prdata", req_prdata, {32'h0, 32'h1234_5678, 32'h0});
        step();
        req_psel = 3'b000; m_pslverr = 1'b0;
        #1;
        chk("ws_after_pslverr", req_pslverr, 0);

        // Reset during an ACCESS wait state (rr_ptr=2 -> req0 granted)
        req_psel = 3'b001; m_pready = 1'b0;
        step(); step(); #1;
        chk("rst_mid_access", {m_psel, m_penable}, 2'b11);
        rst = 1'b1;
        step();
        rst = 1'b0; req_psel = 3'b100; m_pready = 1'b1;
        #1;
        chk("rst_mid_outputs", {m_psel, m_penable, m_paddr, req_pready}, 0);
        chk("rst_mid_rr_ptr", dut.rr_ptr, 0);
        step(); #1;
        chk("rst_then_req2", m_paddr, addr[2]);
        step(); #1;
        chk("rst_then_pready2", req_pready, 3'b100);
        step();
        req_psel = 3'b000;

        // Psel drop: req1 granted from rr_ptr=0, drops psel in SETUP
        req_psel = 3'b010;
        step();
        req_psel = 3'b101;
        #1;
        chk("drop_setup_owner1", {m_psel, m_penable, m_paddr}, {2'b10, addr[1]});
        step(); #1;
        chk("drop_pready1", req_pready, 3'b010);
        step(); step(); #1;
        chk("drop_next_owner2", m_paddr, addr[2]);
        step(); #1;
        chk("drop_pready2", req_pready, 3'b100);
        step();
        req_psel = 3'b000;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
